// File: rtl/sobel_window_feeder_if.sv
// Pixel-stream bundle between the grayscale converter, the window feeder and the Sobel stage.
// Handshake: an input pixel transfers on a rising clk edge where px_rdy_i && in_ready_o;
// px_rdy_i with in_ready_o low is dropped (no backpressure upstream), px_rdy_o is a
// one-cycle strobe per output pixel and the Sobel stage cannot stall it.
interface sobel_window_feeder_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                   frame_start_i;
    logic                   px_rdy_i;
    logic [PIXEL_WIDTH-1:0] in_px_i;
    logic                   in_ready_o;
    logic [PIXEL_WIDTH-1:0] out_px_o;
    logic                   px_rdy_o;
    logic                   start_sobel_o;
    logic                   frame_done_o;
    logic [2:0]             dbg_state_o;

    modport master (
        output frame_start_i, px_rdy_i, in_px_i,
        input  in_ready_o, out_px_o, px_rdy_o, start_sobel_o, frame_done_o, dbg_state_o
    );

    modport slave (
        input  frame_start_i, px_rdy_i, in_px_i,
        output in_ready_o, out_px_o, px_rdy_o, start_sobel_o, frame_done_o, dbg_state_o
    );
endinterface

// File: rtl/sobel_window_feeder.sv
// Buffers two image lines and serialises a (top, mid, bot) pixel column per input pixel
// from row 2 onward, framing each output row with start_sobel_o.
module sobel_window_feeder #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16,
    parameter int COL_BITS    = $clog2(IMG_WIDTH),
    parameter int ROW_BITS    = $clog2(IMG_HEIGHT)
) (
    input logic                  clk_i,
    input logic                  nreset_i,
    sobel_window_feeder_if.slave bus
);

    typedef enum logic [2:0] {
        ST_ACCEPT   = 3'd0,
        ST_EMIT_TOP = 3'd1,
        ST_EMIT_MID = 3'd2,
        ST_EMIT_BOT = 3'd3,
        ST_ROW_GAP  = 3'd4
    } state_t;

    localparam logic [COL_BITS-1:0] LAST_COL      = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW      = ROW_BITS'(IMG_HEIGHT - 1);
    localparam logic [ROW_BITS-1:0] FIRST_OUT_ROW = ROW_BITS'(2);

    state_t                 r_state;
    logic [COL_BITS-1:0]    r_col;
    logic [ROW_BITS-1:0]    r_row;
    logic [PIXEL_WIDTH-1:0] r_out_px;
    logic [PIXEL_WIDTH-1:0] r_mid;
    logic [PIXEL_WIDTH-1:0] r_bot;
    logic                   r_px_rdy;
    logic                   r_start;
    logic                   r_done;
    logic                   r_in_ready;
    logic                   r_last_col;
    logic                   r_last_row;

    // line_a holds row r-2, line_b holds row r-1 at each column
    logic [PIXEL_WIDTH-1:0] r_line_a [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] r_line_b [IMG_WIDTH];

    logic                   w_accept;
    logic [COL_BITS-1:0]    w_wr_col;

    assign w_accept = bus.px_rdy_i && r_in_ready;
    assign w_wr_col = bus.frame_start_i ? '0 : r_col;

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_line_a[w_wr_col] <= r_line_b[w_wr_col];
            r_line_b[w_wr_col] <= bus.in_px_i;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state    <= ST_ACCEPT;
            r_col      <= '0;
            r_row      <= '0;
            r_out_px   <= '0;
            r_mid      <= '0;
            r_bot      <= '0;
            r_px_rdy   <= 1'b0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b1;
            r_last_col <= 1'b0;
            r_last_row <= 1'b0;
        end else if (bus.frame_start_i) begin
            // A pixel accepted alongside frame start becomes (row 0, col 0)
            r_state    <= ST_ACCEPT;
            r_in_ready <= 1'b1;
            r_px_rdy   <= 1'b0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_row      <= '0;
            r_col      <= w_accept ? COL_BITS'(1) : '0;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_last_col <= (r_col == LAST_COL);
                        r_last_row <= (r_row == LAST_ROW);
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_BITS'(1);
                        end else begin
                            r_col <= r_col + COL_BITS'(1);
                        end
                        if (r_row >= FIRST_OUT_ROW) begin
                            r_state    <= ST_EMIT_TOP;
                            r_in_ready <= 1'b0;
                            r_px_rdy   <= 1'b1;
                            r_out_px   <= r_line_a[r_col];
                            r_mid      <= r_line_b[r_col];
                            r_bot      <= bus.in_px_i;
                            if (r_col == '0) begin
                                r_start <= 1'b1;
                            end
                        end
                    end
                end
                ST_EMIT_TOP: begin
                    r_state  <= ST_EMIT_MID;
                    r_out_px <= r_mid;
                end
                ST_EMIT_MID: begin
                    r_state  <= ST_EMIT_BOT;
                    r_out_px <= r_bot;
                end
                ST_EMIT_BOT: begin
                    r_px_rdy <= 1'b0;
                    if (r_last_col) begin
                        r_state <= ST_ROW_GAP;
                        r_start <= 1'b0;
                        r_done  <= r_last_row;
                    end else begin
                        r_state    <= ST_ACCEPT;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_ROW_GAP: begin
                    r_state    <= ST_ACCEPT;
                    r_in_ready <= 1'b1;
                    r_done     <= 1'b0;
                end
                default: begin
                    r_state    <= ST_ACCEPT;
                    r_in_ready <= 1'b1;
                    r_px_rdy   <= 1'b0;
                    r_start    <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o    = r_in_ready;
    assign bus.out_px_o      = r_out_px;
    assign bus.px_rdy_o      = r_px_rdy;
    assign bus.start_sobel_o = r_start;
    assign bus.frame_done_o  = r_done;
    assign bus.dbg_state_o   = r_state;

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder on a 4x4 image: vector table for one frame,
// then hand sequences for continuous input, frame restart and asynchronous reset.
module tb_sobel_window_feeder;

    typedef struct {
        logic [7:0] px;
        logic       emit;
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
        logic       start_after;
        logic       done_after;
    } vec_t;

    logic clk = 1'b0;
    logic nreset = 1'b1;

    sobel_window_feeder_if #(.PIXEL_WIDTH(8)) bus ();

    sobel_window_feeder #(
        .PIXEL_WIDTH(8),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (4)
    ) dut (
        .clk_i   (clk),
        .nreset_i(nreset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int strobes = 0;
    int done_cnt = 0;
    int row_strobes = 0;
    int low_cnt = 100;
    logic prev_start = 1'b0;
    logic row_chk_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(input logic [7:0] px);
        int w = 0;
        while (!bus.in_ready_o && w < 20) begin
            step();
            w++;
        end
        chk("ready_wait", bus.in_ready_o, 1);
        bus.px_rdy_i = 1'b1;
        bus.in_px_i  = px;
        step();
        bus.px_rdy_i = 1'b0;
    endtask

    // Scoreboard and row-framing monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (nreset) begin
            if (bus.px_rdy_o) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_px", {24'd0, bus.out_px_o}, 32'hFFFF_FFFF);
                end else begin
                    chk("px_value", {24'd0, bus.out_px_o}, {24'd0, exp_q.pop_front()});
                end
                if (row_chk_en) chk("start_with_px", bus.start_sobel_o, 1);
            end
            if (row_chk_en) begin
                if (bus.start_sobel_o) begin
                    if (!prev_start) chk("row_gap_ge2", (low_cnt >= 2), 1);
                    if (bus.px_rdy_o) row_strobes++;
                    low_cnt = 0;
                end else begin
                    if (prev_start) chk("row_strobes", row_strobes, 12);
                    row_strobes = 0;
                    low_cnt++;
                end
            end
            prev_start = bus.start_sobel_o;
            if (bus.frame_done_o) done_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[16];
        int   exp_cyc[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 25, 29, 33, 37};
        int   acc_cyc[16];
        int   n_acc;
        int   cyc;
        int   strobes_before;
        logic acc;

        vecs[0]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{8'h02, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{8'h03, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{8'h04, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{8'h05, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{8'h06, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{8'h07, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'h08, 1'b1, 8'h00, 8'h04, 8'h08, 1'b1, 1'b0};
        vecs[9]  = '{8'h09, 1'b1, 8'h01, 8'h05, 8'h09, 1'b1, 1'b0};
        vecs[10] = '{8'h0A, 1'b1, 8'h02, 8'h06, 8'h0A, 1'b1, 1'b0};
        vecs[11] = '{8'h0B, 1'b1, 8'h03, 8'h07, 8'h0B, 1'b0, 1'b0};
        vecs[12] = '{8'h0C, 1'b1, 8'h04, 8'h08, 8'h0C, 1'b1, 1'b0};
        vecs[13] = '{8'h0D, 1'b1, 8'h05, 8'h09, 8'h0D, 1'b1, 1'b0};
        vecs[14] = '{8'h0E, 1'b1, 8'h06, 8'h0A, 8'h0E, 1'b1, 1'b0};
        vecs[15] = '{8'h0F, 1'b1, 8'h07, 8'h0B, 8'h0F, 1'b0, 1'b1};

        bus.frame_start_i = 1'b0;
        bus.px_rdy_i      = 1'b0;
        bus.in_px_i       = 8'h00;

        // Reset values
        #1 nreset = 1'b0;
        #1;
        chk("rst_out_px", {24'd0, bus.out_px_o}, 0);
        chk("rst_px_rdy", bus.px_rdy_o, 0);
        chk("rst_start", bus.start_sobel_o, 0);
        chk("rst_done", bus.frame_done_o, 0);
        chk("rst_ready", bus.in_ready_o, 1);
        chk("rst_state", {29'd0, bus.dbg_state_o}, 0);
        repeat (2) step();
        #2 nreset = 1'b1;
        step();

        // One full frame, one pixel per 4 cycles
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].emit) begin
                exp_q.push_back(vecs[i].top);
                exp_q.push_back(vecs[i].mid);
                exp_q.push_back(vecs[i].bot);
            end
            send_px(vecs[i].px);
            chk("t1_emit", bus.px_rdy_o, {31'd0, vecs[i].emit});
            if (vecs[i].emit) begin
                chk("t1_start_top", bus.start_sobel_o, 1);
                step();
                step();
                chk("t1_strobe_bot", bus.px_rdy_o, 1);
                step();
                chk("t1_strobe_end", bus.px_rdy_o, 0);
                chk("t1_start_after", bus.start_sobel_o, {31'd0, vecs[i].start_after});
                chk("t1_done", bus.frame_done_o, {31'd0, vecs[i].done_after});
            end else begin
                chk("t1_ready_fill", bus.in_ready_o, 1);
                repeat (3) step();
            end
        end
        repeat (2) step();
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_q_empty", exp_q.size(), 0);

        // px_rdy_i held high: accept timing set by in_ready_o
        bus.frame_start_i = 1'b1;
        step();
        bus.frame_start_i = 1'b0;
        strobes_before = strobes;
        bus.px_rdy_i = 1'b1;
        bus.in_px_i  = 8'h40;
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 16 && cyc < 100) begin
            acc = bus.in_ready_o;
            if (acc && n_acc >= 8) begin
                exp_q.push_back(8'(8'h40 + n_acc - 8));
                exp_q.push_back(8'(8'h40 + n_acc - 4));
                exp_q.push_back(8'(8'h40 + n_acc));
            end
            step();
            if (acc) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                bus.in_px_i = 8'(8'h40 + n_acc);
                if (n_acc == 16) bus.px_rdy_i = 1'b0;
            end
            cyc++;
        end
        bus.px_rdy_i = 1'b0;
        chk("t2_accepts", n_acc, 16);
        for (int i = 0; i < 16; i++) chk("t2_acc_cycle", acc_cyc[i], exp_cyc[i]);
        repeat (6) step();
        chk("t2_strobes", strobes - strobes_before, 24);
        chk("t2_done_cnt", done_cnt, 2);
        chk("t2_q_empty", exp_q.size(), 0);

        // Frame restart during EMIT_MID of row 2, column 1
        row_chk_en = 1'b0;
        bus.frame_start_i = 1'b1;
        step();
        bus.frame_start_i = 1'b0;
        for (int k = 0; k < 8; k++) send_px(8'(8'h80 + k));
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h84);
        exp_q.push_back(8'h88);
        send_px(8'h88);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h85);
        send_px(8'h89);
        step();
        chk("t3_in_mid", {29'd0, bus.dbg_state_o}, 2);
        bus.frame_start_i = 1'b1;
        step();
        bus.frame_start_i = 1'b0;
        chk("t3_px_rdy", bus.px_rdy_o, 0);
        chk("t3_start", bus.start_sobel_o, 0);
        chk("t3_ready", bus.in_ready_o, 1);
        chk("t3_state", {29'd0, bus.dbg_state_o}, 0);
        for (int k = 0; k < 8; k++) begin
            send_px(8'(8'hC0 + k));
            chk("t3_quiet", bus.px_rdy_o, 0);
        end
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC4);
        exp_q.push_back(8'hC8);
        send_px(8'hC8);
        chk("t3_top", {24'd0, bus.out_px_o}, 32'hC0);
        repeat (3) step();

        // Frame start and accept in the same cycle
        chk("t4_pre_ready", bus.in_ready_o, 1);
        bus.frame_start_i = 1'b1;
        bus.px_rdy_i      = 1'b1;
        bus.in_px_i       = 8'hAA;
        step();
        bus.frame_start_i = 1'b0;
        bus.px_rdy_i      = 1'b0;
        chk("t4_state", {29'd0, bus.dbg_state_o}, 0);
        chk("t4_px_rdy", bus.px_rdy_o, 0);
        chk("t4_ready", bus.in_ready_o, 1);
        send_px(8'h01);
        send_px(8'h02);
        send_px(8'h03);
        send_px(8'h10);
        send_px(8'h11);
        send_px(8'h12);
        send_px(8'h13);
        chk("t4_quiet", bus.px_rdy_o, 0);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        send_px(8'h20);
        chk("t4_top", {24'd0, bus.out_px_o}, 32'hAA);
        repeat (3) step();

        // Asynchronous reset during EMIT_TOP
        send_px(8'h21);
        chk("t5_pre_px_rdy", bus.px_rdy_o, 1);
        chk("t5_pre_start", bus.start_sobel_o, 1);
        #1 nreset = 1'b0;
        #1;
        chk("t5_out_px", {24'd0, bus.out_px_o}, 0);
        chk("t5_px_rdy", bus.px_rdy_o, 0);
        chk("t5_start", bus.start_sobel_o, 0);
        chk("t5_ready", bus.in_ready_o, 1);
        chk("t5_done", bus.frame_done_o, 0);
        chk("t5_state", {29'd0, bus.dbg_state_o}, 0);
        #1 nreset = 1'b1;
        step();
        chk("t5_after_ready", bus.in_ready_o, 1);
        chk("t5_after_px_rdy", bus.px_rdy_o, 0);

        chk("final_q_empty", exp_q.size(), 0);
        chk("final_done_cnt", done_cnt, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
